// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with req/ack memory port and decoder handshake.
// Optional FETCH_PERF_EN adds saturating transfer/stall counters.
module fetch_unit #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    input  logic                    mem_ack,
    input  logic [ADDRESS_SIZE-1:0] mem_data,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [ADDRESS_SIZE-1:0] branch_target,
    output logic [ADDRESS_SIZE-1:0] instruction,
    output logic [ADDRESS_SIZE-1:0] instr_pc,
    output logic                    instr_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             fetch_count,
    output logic [31:0]             stall_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_FLUSH = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDRESS_SIZE-1:0] pc;
    logic [ADDRESS_SIZE-1:0] pc_nxt;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [ADDRESS_SIZE-1:0] target;
    logic                    req_en;
    logic                    ack;
    logic                    load;
    logic                    clear_valid;

    // pc is the next fetch address; addr_q is the address on the bus, which
    // must stay put while a flushed request drains.
    assign target   = branch_target & ~ADDRESS_SIZE'(3);
    assign mem_req  = req_en && (state == S_REQ || state == S_FLUSH);
    assign mem_addr = addr_q;
    assign ack      = mem_ack && mem_req;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        load        = 1'b0;
        clear_valid = 1'b0;
        case (state)
            S_REQ: begin
                if (branch_taken) begin
                    pc_nxt    = target;
                    state_nxt = (mem_req && !ack) ? S_FLUSH : S_REQ;
                end else if (ack) begin
                    load      = 1'b1;
                    pc_nxt    = pc + ADDRESS_SIZE'(4);
                    state_nxt = S_OUT;
                end
            end
            S_FLUSH: begin
                if (branch_taken) begin
                    pc_nxt = target;
                end
                if (ack) begin
                    state_nxt = S_REQ;
                end
            end
            S_OUT: begin
                // a redirect squashes the presented word even if the decoder takes it
                if (branch_taken) begin
                    pc_nxt      = target;
                    clear_valid = 1'b1;
                    state_nxt   = S_REQ;
                end else if (!stall) begin
                    clear_valid = 1'b1;
                    state_nxt   = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            addr_q      <= RESET_PC;
            req_en      <= 1'b0;
            instruction <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            req_en <= 1'b1;
            if (state_nxt == S_REQ) begin
                addr_q <= pc_nxt;
            end
            if (load) begin
                instruction <= mem_data;
                instr_pc    <= addr_q;
                instr_valid <= 1'b1;
            end else if (clear_valid) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else if (state == S_OUT) begin
            if (!stall && !branch_taken && fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall && stall_count != 32'hFFFF_FFFF) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with randomized memory/stall/branch traffic.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;

    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic [31:0] w_instruction;
    logic [31:0] w_instr_pc;
    logic        w_instr_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] w_fetch_count;
    logic [31:0] w_stall_count;
`endif

    fetch_unit #(.ADDRESS_SIZE(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_unit #(.ADDRESS_SIZE(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(w_instruction), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid)
`ifdef FETCH_PERF_EN
        , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          ack_pct  = 0;
    int          n_xfer   = 0;
    int          fetch_m  = 0;
    int          stall_m  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected program order from a given start address: sequential words.
    task automatic restart_model(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0 && exp_q.size() < 16) exp_q.push_back(exp_q[$] + 32'd4);
    endtask

    task automatic wait_for_valid();
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        check("wait_valid", instr_valid, 1'b1);
    endtask

    task automatic wait_for_req();
        for (int i = 0; i < 20 && !mem_req; i++) step();
        check("wait_req", mem_req, 1'b1);
    endtask

    // Memory model: acks at a programmable rate, data derived from the address.
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack  = ($urandom_range(0, 99) < ack_pct);
            mem_data = (mem_ack && mem_req) ? (mem_addr ^ KEY) : $urandom();
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks bus protocol.
    initial begin
        logic        prev_xfer;
        logic        pend;
        logic [31:0] pend_addr;
        logic        xfer;
        logic [31:0] e;
        prev_xfer = 1'b0;
        pend      = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_xfer = 1'b0;
                pend      = 1'b0;
                fetch_m   = 0;
                stall_m   = 0;
            end else begin
                if (prev_xfer) check("valid_drop", instr_valid, 1'b0);
                if (pend) begin
                    check("hold_req", mem_req, 1'b1);
                    check("hold_addr", mem_addr, pend_addr);
                end
                if (mem_req) check("addr_align", mem_addr[1:0], 2'b00);
                xfer = instr_valid && !stall && !branch_taken;
                if (instr_valid && stall) stall_m++;
                if (xfer) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty actual=transfer expected=none");
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", instr_pc, e);
                        check("instruction", instruction, e ^ KEY);
                    end
                    n_xfer++;
                    fetch_m++;
                end
                prev_xfer = xfer;
                pend      = mem_req && !mem_ack;
                pend_addr = mem_addr;
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          r;
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        ack_pct       = 100;
        restart_model(32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_req", mem_req, 1'b0);

        // sequential fetch with ack every cycle; wrap checked on the second instance
        step();
        reset = 1'b1;
        step();
        check("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 32'h0);
        check("w_first_addr", w_mem_addr, 32'hFFFF_FFFC);
        step();
        check("w_valid", w_instr_valid, 1'b1);
        check("w_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
        step();
        check("w_wrap_req", w_mem_req, 1'b1);
        check("w_wrap_addr", w_mem_addr, 32'h0);
        repeat (6) step();

        // decoder stall for 5 cycles
        wait_for_valid();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", instr_valid, 1'b1);
            check("stall_noreq", mem_req, 1'b0);
            check("stall_pc", instr_pc, exp_q[0]);
            step();
        end
        stall = 1'b0;
        step();

        // branch while a request is outstanding; ack arrives 3 cycles later
        ack_pct = 0;
        wait_for_req();
        a             = mem_addr;
        branch_taken  = 1'b1;
        branch_target = 32'h103;
        restart_model(32'h100);
        step();
        branch_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("flush_addr", mem_addr, a);
            step();
        end
        ack_pct = 100;
        check("flush_addr", mem_addr, a);
        step();
        check("redir_req", mem_req, 1'b1);
        check("redir_addr", mem_addr, 32'h100);
        repeat (4) step();

        // branch while presenting with stall held
        wait_for_valid();
        stall = 1'b1;
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        restart_model(32'h200);
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("squash_valid", instr_valid, 1'b0);
        check("squash_addr", mem_addr, 32'h200);
        repeat (4) step();

        // reset mid-request; a late ack must be ignored
        ack_pct = 0;
        wait_for_req();
        reset = 1'b0;
        restart_model(32'h0);
        step();
        reset   = 1'b1;
        ack_pct = 100;
        check("midrst_req", mem_req, 1'b0);
        step();
        check("midrst_req2", mem_req, 1'b1);
        check("midrst_addr", mem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            reset        = 1'b1;
            branch_taken = 1'b0;
            if (i % 100 == 0) ack_pct = $urandom_range(20, 100);
            r = $urandom_range(0, 299);
            if (r == 0) begin
                reset = 1'b0;
                restart_model(32'h0);
            end else if (r < 16) begin
                branch_taken  = 1'b1;
                branch_target = $urandom();
                restart_model(branch_target & ~32'h3);
            end
            stall = ($urandom_range(0, 2) == 0);
        end
        reset        = 1'b1;
        branch_taken = 1'b0;
        stall        = 1'b0;
        step();
        check("progress", 32'(n_xfer >= 200), 32'd1);
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, 32'(fetch_m));
        check("stall_count", stall_count, 32'(stall_m));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
